// File: rtl/input_deserializer_n.sv
// Multi-channel serial-to-parallel deserializer with shared bit counter and bit-slip alignment.
// Optional INPUT_DESER_SYNC_EN adds a 2-flop synchroniser on in[] and bitslip.
module input_deserializer_n #(
    parameter int WIDTH     = 16,
    parameter int CHANNELS  = 1,
    parameter int LSB_FIRST = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      bitslip,
    input  logic [CHANNELS-1:0]       in,
    output logic [CHANNELS*WIDTH-1:0] data,
    output logic                      valid,
    output logic                      slip_busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [CHANNELS-1:0] in_s;
    logic                bitslip_s;

`ifdef INPUT_DESER_SYNC_EN
    logic [CHANNELS-1:0] in_meta_r;
    logic [CHANNELS-1:0] in_sync_r;
    logic                bitslip_meta_r;
    logic                bitslip_sync_r;

    // Two-stage synchroniser for asynchronous pad inputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            in_meta_r      <= '0;
            in_sync_r      <= '0;
            bitslip_meta_r <= 1'b0;
            bitslip_sync_r <= 1'b0;
        end else begin
            in_meta_r      <= in;
            in_sync_r      <= in_meta_r;
            bitslip_meta_r <= bitslip;
            bitslip_sync_r <= bitslip_meta_r;
        end
    end

    assign in_s      = in_sync_r;
    assign bitslip_s = bitslip_sync_r;
`else
    assign in_s      = in;
    assign bitslip_s = bitslip;
`endif

    logic [WIDTH-1:0]    shift_r     [CHANNELS];
    logic [WIDTH-1:0]    shift_nxt_s [CHANNELS];
    logic [CW-1:0]       cnt_r;
    logic [CW-1:0]       cnt_nxt_s;
    logic                bitslip_q_r;
    logic                slip_busy_r;
    logic                slip_busy_nxt_s;
    logic                valid_r;
    logic [CHANNELS*WIDTH-1:0] data_r;
    logic                rise_s;
    logic                shift_en_s;
    logic                complete_s;

    assign rise_s = bitslip_s & ~bitslip_q_r;

    // Candidate shift-register contents with this cycle's bit inserted.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (LSB_FIRST != 0) begin
                shift_nxt_s[c] = {in_s[c], shift_r[c][WIDTH-1:1]};
            end else begin
                shift_nxt_s[c] = {shift_r[c][WIDTH-2:0], in_s[c]};
            end
        end
    end

    // Counter / slip control: a pending slip consumes one enabled sample without shifting.
    always_comb begin
        cnt_nxt_s       = cnt_r;
        slip_busy_nxt_s = slip_busy_r;
        shift_en_s      = 1'b0;
        complete_s      = 1'b0;
        if (enable && slip_busy_r) begin
            slip_busy_nxt_s = 1'b0;
        end else if (enable) begin
            shift_en_s = 1'b1;
            if (cnt_r == LAST_CNT) begin
                cnt_nxt_s  = '0;
                complete_s = 1'b1;
            end else begin
                cnt_nxt_s = cnt_r + CW'(1);
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
        // An edge arriving while a slip is pending is dropped, never queued.
        if (rise_s && !slip_busy_r) begin
            slip_busy_nxt_s = 1'b1;
        end else begin
            slip_busy_nxt_s = slip_busy_nxt_s;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_r       <= '0;
            bitslip_q_r <= 1'b0;
            slip_busy_r <= 1'b0;
            valid_r     <= 1'b0;
            data_r      <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                shift_r[c] <= '0;
            end
        end else begin
            cnt_r       <= cnt_nxt_s;
            bitslip_q_r <= bitslip_s;
            slip_busy_r <= slip_busy_nxt_s;
            valid_r     <= complete_s;
            for (int c = 0; c < CHANNELS; c++) begin
                if (shift_en_s) begin
                    shift_r[c] <= shift_nxt_s[c];
                end else begin
                    shift_r[c] <= shift_r[c];
                end
                if (complete_s) begin
                    data_r[c*WIDTH +: WIDTH] <= shift_nxt_s[c];
                end else begin
                    data_r[c*WIDTH +: WIDTH] <= data_r[c*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign data      = data_r;
    assign valid     = valid_r;
    assign slip_busy = slip_busy_r;

endmodule

// File: tb/tb_input_deserializer_n.sv
// Table-driven bench for input_deserializer_n (WIDTH=4, CHANNELS=2, LSB_FIRST=1) with a word scoreboard.
module tb_input_deserializer_n;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       bitslip;
    logic [1:0] in;
    logic [7:0] data;
    logic       valid;
    logic       slip_busy;

    input_deserializer_n #(.WIDTH(4), .CHANNELS(2), .LSB_FIRST(1)) dut (
        .clock(clock), .reset(reset), .enable(enable), .bitslip(bitslip),
        .in(in), .data(data), .valid(valid), .slip_busy(slip_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic       rst;
        logic       en;
        logic       bs;
        logic [1:0] din;
        logic       ev;
        logic       eb;
        logic [7:0] ed;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sb[$];
    logic [7:0] last_w;
    int         checks;
    int         failures;

    // Record one cycle; expected data follows reset/completion and otherwise holds.
    task automatic add(input logic rst, input logic en, input logic bs, input logic [1:0] din,
                       input logic ev, input logic eb, input logic [7:0] w);
        vec_t v;
        if (!rst) last_w = 8'h00;
        else if (ev) last_w = w;
        v.rst = rst; v.en = en; v.bs = bs; v.din = din;
        v.ev = ev; v.eb = eb; v.ed = last_w;
        vecs.push_back(v);
    endtask

    initial begin
        logic [7:0] exp_w;
        checks = 0; failures = 0; last_w = 8'h00;
        reset = 1'b0; enable = 1'b0; bitslip = 1'b0; in = 2'b00;

        // Reset held with activity on the inputs
        repeat (3) add(1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 8'h00);
        // Basic word, then continuous stream
        for (int k = 0; k < 3; k++) begin
            add(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 8'h00);
            add(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
            add(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 8'h00);
            add(1'b1, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 8'h8D);
        end
        add(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
        // Enable gaps with junk on the idle cycles
        add(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 8'h8D);
        add(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
        // Reset mid-word discards the partial word
        add(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 8'h00);
        add(1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 8'h06);
        // Bitslip on a 1,0,0,0 stream on ch0
        add(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 8'h01);
        add(1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 8'h00);
        add(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 8'h09);
        add(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 8'h08);
        // Bitslip held high for 10 cycles: a single slip
        add(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 8'h00);
        add(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 2; k++) begin
            add(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
            add(1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 8'h00);
            add(1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 8'h04);
            add(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
        end
        add(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 8'h04);
        // Slip pending across enable=0; a second edge while busy is ignored
        add(1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 8'h00);
        add(1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1, 8'h00);
        add(1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 8'h00);
        add(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 8'h08);
        // Slip edge coinciding with word completion
        add(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 8'h01);
        add(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 8'h08);
        add(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            reset   = vecs[i].rst;
            enable  = vecs[i].en;
            bitslip = vecs[i].bs;
            in      = vecs[i].din;
            if (vecs[i].ev) sb.push_back(vecs[i].ed);
            @(posedge clock);
            #1;
            checks++;
            if (valid !== vecs[i].ev) begin
                failures++;
                $display("FAIL valid row=%0d actual=%b required=%b", i, valid, vecs[i].ev);
            end
            checks++;
            if (slip_busy !== vecs[i].eb) begin
                failures++;
                $display("FAIL slip_busy row=%0d actual=%b required=%b", i, slip_busy, vecs[i].eb);
            end
            checks++;
            if (data !== vecs[i].ed) begin
                failures++;
                $display("FAIL data row=%0d actual=%h required=%h", i, data, vecs[i].ed);
            end
            if (valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_word row=%0d actual=%h required=none", i, data);
                end else begin
                    exp_w = sb.pop_front();
                    if (data !== exp_w) begin
                        failures++;
                        $display("FAIL sb_word row=%0d actual=%h required=%h", i, data, exp_w);
                    end
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
